// File: rtl/score_bcd_converter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types, constants and helpers for the score BCD
//               converter (digit type, FSM state encoding, decimal limit).
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam bcd_digit_t C_BCD_NINE     = 4'd9;
  localparam bcd_digit_t C_ADD3_THRESH  = 4'd5;
  localparam bcd_digit_t C_ADD3_OFFSET  = 4'd3;

  // Largest value representable with the given number of decimal digits.
  function automatic int max_decimal(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : score_bcd_converter_if
// Description : Request / result bundle between the score registers and the
//               BCD converter. master = requester, slave = converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface score_bcd_converter_if
  import bcd_pkg::*;
#(
  parameter int IN_W = 10
) ();

  logic            start;
  logic [IN_W-1:0] value;
  logic            frame_sync;
  logic            busy;
  logic            done;
  logic            overflow;
  bcd_digit_t      hundreds;
  bcd_digit_t      tens;
  bcd_digit_t      ones;

  modport master (
    output start, value, frame_sync,
    input  busy, done, overflow, hundreds, tens, ones
  );

  modport slave (
    input  start, value, frame_sync,
    output busy, done, overflow, hundreds, tens, ones
  );

endinterface
`default_nettype wire

// File: rtl/score_bcd_converter_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Double-dabble digit correction: adds 3 to a BCD digit that
//               is 5 or more so the following left shift carries correctly.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  // Inputs are always <= 9 here, so the sum never exceeds 12 and fits 4 bits.
  assign o_digit = (i_digit >= C_ADD3_THRESH) ? (i_digit + C_ADD3_OFFSET) : i_digit;

endmodule
`default_nettype wire

// File: rtl/score_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : score_bcd_converter
// Description : Multi-cycle shift-and-add-3 binary to BCD converter with a
//               staged result that is committed to the digit outputs either
//               on frame_sync (tear-free display) or directly after DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_converter
  import bcd_pkg::*;
#(
  parameter int IN_W            = 10,
  parameter int DIGITS          = 3,   // must be >= 3 to feed the three digit ports
  parameter bit COMMIT_ON_FRAME = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  score_bcd_converter_if.slave  bus
);

  localparam int                SCR_W      = 4 * DIGITS;
  localparam int                CNT_W      = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [31:0]       C_MAX      = 32'(max_decimal(DIGITS));
  localparam logic [SCR_W-1:0]  C_ALL_NINE = {DIGITS{C_BCD_NINE}};
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(IN_W - 1);

  bcd_state_t        r_state;
  bcd_state_t        w_next_state;

  logic [IN_W-1:0]   r_bin;       // binary shift register
  logic [SCR_W-1:0]  r_bcd;       // BCD scratch
  logic [CNT_W-1:0]  r_cnt;       // remaining shift steps
  logic              r_sat;       // captured value exceeds decimal range

  logic [SCR_W-1:0]  r_stg;       // staged result awaiting commit
  logic              r_stg_ovf;
  logic              r_pending;
  logic [SCR_W-1:0]  r_out;       // committed, display-visible digits
  logic              r_out_ovf;

  logic [SCR_W-1:0]  w_adj;
  logic [SCR_W-1:0]  w_result;
  logic              w_busy;
  logic              w_done;

  // Per-digit +3 correction applied before each shift; slices never carry.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .i_digit (r_bcd[4*gi +: 4]),
        .o_digit (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Saturation was decided at capture; the scratch is ignored in that case.
  assign w_result = r_sat ? C_ALL_NINE : r_bcd;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one SHIFT cycle per input bit, then a single DONE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = SHIFT;
      SHIFT:   if (r_cnt == '0) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      SHIFT:   w_busy = 1'b1;
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  // Conversion datapath: capture, shift-and-add-3, and staging of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_stg     <= '0;
      r_stg_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bin <= bus.value;
            r_bcd <= '0;
            r_cnt <= C_CNT_LAST;
            r_sat <= (32'(bus.value) > C_MAX);
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt - CNT_W'(1);
        end
        DONE: begin
          r_stg     <= w_result;
          r_stg_ovf <= r_sat;
        end
        default: ;
      endcase
    end
  end

  // Commit to the visible digits; a DONE coinciding with frame_sync commits
  // the fresh result directly rather than the older staged one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_ovf <= 1'b0;
      r_pending <= 1'b0;
    end else if (COMMIT_ON_FRAME) begin
      if (bus.frame_sync) begin
        if (w_done) begin
          r_out     <= w_result;
          r_out_ovf <= r_sat;
        end else if (r_pending) begin
          r_out     <= r_stg;
          r_out_ovf <= r_stg_ovf;
        end
        r_pending <= 1'b0;
      end else if (w_done) begin
        r_pending <= 1'b1;
      end
    end else begin
      if (w_done) begin
        r_out     <= w_result;
        r_out_ovf <= r_sat;
      end
      r_pending <= 1'b0;
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.overflow = r_out_ovf;
  assign bus.hundreds = r_out[11:8];
  assign bus.tens     = r_out[7:4];
  assign bus.ones     = r_out[3:0];

endmodule
`default_nettype wire
